// File: rtl/scratch_bank_defs.sv
// scratch_bank shared definitions: default register numbers and AW helper.
// Optional feature macro: SCRATCH_BANK_AUTOINC_EN (see scratch_bank.sv).
package scratch_bank_defs;

  localparam logic [7:0] DEF_INDEX_ADDR = 8'hFC;
  localparam logic [7:0] DEF_DATA_ADDR  = 8'hFD;

  function automatic int log2c(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/scratch_bank_if.sv
// ZX-Uno register bus slice seen by scratch_bank.
// Optional feature macro: SCRATCH_BANK_AUTOINC_EN (consumer side only).
interface scratch_bank_if;

  logic [7:0] zxuno_addr;
  logic       zxuno_regrd;
  logic       zxuno_regwr;
  logic [7:0] din;
  logic [7:0] dout;
  logic       oe_n;

  modport master (
    output zxuno_addr,
    output zxuno_regrd,
    output zxuno_regwr,
    output din,
    input  dout,
    input  oe_n
  );

  modport slave (
    input  zxuno_addr,
    input  zxuno_regrd,
    input  zxuno_regwr,
    input  din,
    output dout,
    output oe_n
  );

endinterface

// File: rtl/zxuno_access_edge.sv
// Start/end pulse generator for level-strobed ZX-Uno register accesses.
// Reusable by any auto-incrementing port; SCRATCH_BANK_AUTOINC_EN not used here.
module zxuno_access_edge (
  input  logic clk,
  input  logic rst,
  input  logic acc,
  input  logic regrd,
  input  logic regwr,
  output logic start,
  output logic done,
  output logic prev_acc
);

  logic busy;

  assign start = acc & ~prev_acc;
  // End is judged on raw strobes only: the address may move before they drop.
  assign done  = busy & ~regrd & ~regwr;

  always_ff @(posedge clk) begin
    if (rst) begin
      prev_acc <= 1'b0;
      busy     <= 1'b0;
    end else begin
      prev_acc <= acc;
      if (start)
        busy <= 1'b1;
      else if (done)
        busy <= 1'b0;
    end
  end

endmodule

// File: rtl/scratch_bank.sv
// Bank of DEPTH scratch bytes behind an INDEX register and a DATA port.
// Define SCRATCH_BANK_AUTOINC_EN to step the index after each DATA access.
module scratch_bank
  import scratch_bank_defs::*;
#(
  parameter logic [7:0] INDEX_ADDR = DEF_INDEX_ADDR,
  parameter logic [7:0] DATA_ADDR  = DEF_DATA_ADDR,
  parameter int         DEPTH      = 16
) (
  input logic           clk,
  input logic           poweron_rst,
  scratch_bank_if.slave bus
);

  localparam int AW = log2c(DEPTH);

  logic          sel_idx;
  logic          sel_dat;
  logic          acc;
  logic          start;
  logic          done;
  logic          prev_acc;
  logic          idx_wr;
  logic          dat_wr;
  logic          bump;
  logic          unused_edge;
  logic [AW-1:0] index;
  logic [7:0]    rd_val;
  logic [7:0]    mem [DEPTH];

  assign sel_idx = bus.zxuno_addr == INDEX_ADDR;
  assign sel_dat = bus.zxuno_addr == DATA_ADDR;

  assign acc = (bus.zxuno_regrd | bus.zxuno_regwr)
             & (sel_idx | sel_dat);

  assign bus.oe_n = ~((sel_idx | sel_dat) & bus.zxuno_regrd);

  zxuno_access_edge u_edge (
    .clk      (clk),
    .rst      (poweron_rst),
    .acc      (acc),
    .regrd    (bus.zxuno_regrd),
    .regwr    (bus.zxuno_regwr),
    .start    (start),
    .done     (done),
    .prev_acc (prev_acc)
  );

  // Write wins when both strobes are up at the start cycle.
  assign idx_wr = start & bus.zxuno_regwr & sel_idx;
  assign dat_wr = start & bus.zxuno_regwr & sel_dat;

`ifdef SCRATCH_BANK_AUTOINC_EN
  logic pend;

  always_ff @(posedge clk) begin
    if (poweron_rst)
      pend <= 1'b0;
    else if (idx_wr)
      pend <= 1'b0;
    else if (start & sel_dat)
      pend <= 1'b1;
    else if (done)
      pend <= 1'b0;
  end

  assign bump        = done & pend;
  assign unused_edge = prev_acc;
`else
  assign bump        = 1'b0;
  assign unused_edge = prev_acc ^ done;
`endif

  always_ff @(posedge clk) begin
    if (poweron_rst)
      index <= '0;
    else if (idx_wr)
      index <= bus.din[AW-1:0];
    else if (bump)
      index <= index + AW'(1);
  end

  always_ff @(posedge clk) begin
    if (poweron_rst) begin
      for (int i = 0; i < DEPTH; i++)
        mem[i] <= 8'h00;
    end else if (dat_wr) begin
      mem[index] <= bus.din;
    end
  end

  always_comb begin
    rd_val = 8'h00;
    unique case (1'b1)
      sel_idx: rd_val = 8'(index);
      sel_dat: rd_val = mem[index];
      default: rd_val = 8'h00;
    endcase
  end

  always_ff @(posedge clk) begin
    if (poweron_rst)
      bus.dout <= 8'h00;
    else
      bus.dout <= rd_val;
  end

endmodule
